// File: rtl/ysyx_22040088_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, EXU redirect and
// the decode-facing output register.
//
// Handshake rules: a request transfers on the rising edge where imem_req_valid
// and imem_req_ready are both 1. While valid is high and ready is low, the
// address does not change unless a redirect arrives. The output channel
// transfers when out_valid and out_ready are both 1. While waiting for
// out_ready, out_* hold their values. imem_resp_valid is a one-cycle strobe
// and has no ready.
interface ysyx_22040088_fetch_if #(
    parameter int XLEN   = 64,
    parameter int INST_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_resp_valid;
    logic [INST_W-1:0] imem_resp_data;
    logic              imem_resp_err;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [XLEN-1:0]   out_pc;
    logic              out_err;

    // Fetch stage view
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data, imem_resp_err,
        input  redirect_valid, redirect_pc,
        output out_valid, out_inst, out_pc, out_err,
        input  out_ready
    );

    // Memory / EXU / IDU view
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data, imem_resp_err,
        output redirect_valid, redirect_pc,
        input  out_valid, out_inst, out_pc, out_err,
        output out_ready
    );
endinterface

// File: rtl/ysyx_22040088_fetch.sv
// Instruction-fetch stage. It owns the fetch PC and keeps at most one memory
// request in flight. It delivers {pc, inst, err} to decode through a
// valid/ready output register. A redirect from EXU squashes any fetch that is
// still in flight.
module ysyx_22040088_fetch #(
    parameter int                XLEN     = 64,
    parameter int                INST_W   = 32,
    parameter logic [XLEN-1:0]   RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    ysyx_22040088_fetch_if.master fetch_bus,
    output logic [1:0]           o_dbg_state
);
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_pc;
    logic              r_kill;
    logic              r_out_valid;
    logic [INST_W-1:0] r_out_inst;
    logic [XLEN-1:0]   r_out_pc;
    logic              r_out_err;

    logic              w_aligned;
    logic              w_req_valid;
    logic              w_req_fire;

    assign w_aligned   = (r_pc[1:0] == 2'b00);
    assign w_req_valid = (r_state == S_REQ) && rst && w_aligned;
    assign w_req_fire  = w_req_valid && fetch_bus.imem_req_ready;

    assign fetch_bus.imem_req_valid = w_req_valid;
    assign fetch_bus.imem_req_addr  = r_pc;
    assign fetch_bus.out_valid      = r_out_valid;
    assign fetch_bus.out_inst       = r_out_inst;
    assign fetch_bus.out_pc         = r_out_pc;
    assign fetch_bus.out_err        = r_out_err;
    assign o_dbg_state              = r_state;

    // Fetch FSM: PC, squash flag and output register. A redirect always wins over pc+4.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_kill      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_inst  <= '0;
            r_out_pc    <= RESET_PC;
            r_out_err   <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (fetch_bus.redirect_valid) begin
                        // If the old address handshakes in this cycle, its
                        // response must still be absorbed and then dropped.
                        r_pc <= fetch_bus.redirect_pc;
                        if (w_req_fire) begin
                            r_state <= S_WAIT;
                            r_kill  <= 1'b1;
                        end
                    end else if (!w_aligned) begin
                        // A misaligned PC never reaches memory. It is reported as a fault.
                        r_state     <= S_HOLD;
                        r_out_valid <= 1'b1;
                        r_out_inst  <= '0;
                        r_out_err   <= 1'b1;
                        r_out_pc    <= r_pc;
                    end else if (w_req_fire) begin
                        r_state <= S_WAIT;
                        r_kill  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (fetch_bus.imem_resp_valid) begin
                        if (r_kill || fetch_bus.redirect_valid) begin
                            r_kill  <= 1'b0;
                            r_state <= S_REQ;
                            if (fetch_bus.redirect_valid) begin
                                r_pc <= fetch_bus.redirect_pc;
                            end
                        end else begin
                            r_out_inst  <= fetch_bus.imem_resp_data;
                            r_out_err   <= fetch_bus.imem_resp_err;
                            r_out_pc    <= r_pc;
                            r_out_valid <= 1'b1;
                            r_state     <= S_HOLD;
                        end
                    end else if (fetch_bus.redirect_valid) begin
                        r_pc   <= fetch_bus.redirect_pc;
                        r_kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (fetch_bus.redirect_valid) begin
                        r_out_valid <= 1'b0;
                        r_pc        <= fetch_bus.redirect_pc;
                        r_state     <= S_REQ;
                    end else if (fetch_bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_pc        <= r_pc + XLEN'(4);
                        r_state     <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22040088_fetch.sv
// Directed bench for the fetch stage. Each scenario task drives the bus cycle
// by cycle and compares against hand-computed values.
module tb_ysyx_22040088_fetch;
    localparam int          XLEN   = 64;
    localparam int          INST_W = 32;
    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
    localparam logic [1:0]  ST_REQ  = 2'd0;
    localparam logic [1:0]  ST_WAIT = 2'd1;
    localparam logic [1:0]  ST_HOLD = 2'd2;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         errors;
    int         checks;

    ysyx_22040088_fetch_if #(.XLEN(XLEN), .INST_W(INST_W)) bus ();

    ysyx_22040088_fetch #(.XLEN(XLEN), .INST_W(INST_W), .RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_bus   (bus),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle. Sample and drive 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver: the current request handshakes. The response comes in the next cycle.
    task automatic drive_fetch(input logic [31:0] data, input logic err);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = data;
        bus.imem_resp_err   = err;
        tick();
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.imem_resp_err   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_pc !== RST_PC) begin errors++; $display("FAIL reset_out_pc got=%h exp=%h", bus.out_pc, RST_PC); end
        checks++; if (bus.out_inst !== 32'h0 || bus.out_err !== 1'b0) begin errors++; $display("FAIL reset_out_inst_err got=%h/%b exp=0/0", bus.out_inst, bus.out_err); end
        checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_forced_low got=%b exp=0", bus.imem_req_valid); end
        rst = 1'b1;
        #1;
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RST_PC) begin errors++; $display("FAIL reset_first_req got=%b/%h exp=1/%h", bus.imem_req_valid, bus.imem_req_addr, RST_PC); end
    endtask

    task automatic test_sequential();
        logic [31:0] insts [3];
        logic [63:0] exp_pc;
        insts[0] = 32'h0000_0413;
        insts[1] = 32'h0010_0493;
        insts[2] = 32'hdead_beef;
        for (int i = 0; i < 3; i++) begin
            exp_pc = RST_PC + 64'(4 * i);
            checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== exp_pc) begin errors++; $display("FAIL seq_req[%0d] got=%b/%h exp=1/%h", i, bus.imem_req_valid, bus.imem_req_addr, exp_pc); end
            drive_fetch(insts[i], 1'b0);
            checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc || bus.out_inst !== insts[i] || bus.out_err !== 1'b0) begin
                errors++; $display("FAIL seq_out[%0d] got=%b/%h/%h/%b exp=1/%h/%h/0", i, bus.out_valid, bus.out_pc, bus.out_inst, bus.out_err, exp_pc, insts[i]);
            end
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL seq_out_drop[%0d] got=%b exp=0", i, bus.out_valid); end
        end
    endtask

    task automatic test_hold_stall();
        checks++; if (bus.imem_req_addr !== 64'h8000_000C) begin errors++; $display("FAIL stall_req_addr got=%h exp=8000000c", bus.imem_req_addr); end
        drive_fetch(32'h1234_5678, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h8000_000C || bus.out_inst !== 32'h1234_5678 || bus.imem_req_valid !== 1'b0) begin
                errors++; $display("FAIL stall_hold[%0d] got=%b/%h/%h req=%b exp=1/8000000c/12345678 req=0", i, bus.out_valid, bus.out_pc, bus.out_inst, bus.imem_req_valid);
            end
            checks++; if (bus.imem_req_addr !== 64'h8000_000C) begin errors++; $display("FAIL stall_pc[%0d] got=%h exp=8000000c", i, bus.imem_req_addr); end
            // A spurious response while holding must not disturb the output.
            bus.imem_resp_valid = (i == 2);
            bus.imem_resp_data  = 32'hffff_ffff;
            tick();
            bus.imem_resp_valid = 1'b0;
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h8000_0010) begin
            errors++; $display("FAIL stall_release got=%b/%b/%h exp=0/1/80000010", bus.out_valid, bus.imem_req_valid, bus.imem_req_addr);
        end
    endtask

    task automatic test_redirect_wait();
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        checks++; if (dbg_state !== ST_WAIT) begin errors++; $display("FAIL rdw_in_wait got=%0d exp=%0d", dbg_state, ST_WAIT); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h8000_0100;
        tick();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.imem_req_valid !== 1'b0 || bus.imem_req_addr !== 64'h8000_0100) begin errors++; $display("FAIL rdw_pc got=%b/%h exp=0/80000100", bus.imem_req_valid, bus.imem_req_addr); end
        tick();
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'hbad0_bad0;
        tick();
        bus.imem_resp_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rdw_dropped got=%b exp=0", bus.out_valid); end
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h8000_0100) begin errors++; $display("FAIL rdw_next_req got=%b/%h exp=1/80000100", bus.imem_req_valid, bus.imem_req_addr); end
        drive_fetch(32'h0000_0073, 1'b0);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h8000_0100 || bus.out_inst !== 32'h0000_0073) begin
            errors++; $display("FAIL rdw_target_out got=%b/%h/%h exp=1/80000100/00000073", bus.out_valid, bus.out_pc, bus.out_inst);
        end
    endtask

    task automatic test_redirect_consume();
        // The fetch unit sits in HOLD with pc 0x80000100.
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h8000_0200;
        tick();
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h8000_0200) begin
            errors++; $display("FAIL rdc_next_req got=%b/%b/%h exp=0/1/80000200", bus.out_valid, bus.imem_req_valid, bus.imem_req_addr);
        end
    endtask

    task automatic test_misaligned();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h8000_0102;
        tick();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.imem_req_valid !== 1'b0 || bus.imem_req_addr !== 64'h8000_0102) begin errors++; $display("FAIL mis_no_req got=%b/%h exp=0/80000102", bus.imem_req_valid, bus.imem_req_addr); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_err !== 1'b1 || bus.out_inst !== 32'h0 || bus.out_pc !== 64'h8000_0102) begin
            errors++; $display("FAIL mis_out got=%b/%b/%h/%h exp=1/1/00000000/80000102", bus.out_valid, bus.out_err, bus.out_inst, bus.out_pc);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h8000_0300;
        tick();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h8000_0300) begin
            errors++; $display("FAIL mis_recover got=%b/%b/%h exp=0/1/80000300", bus.out_valid, bus.imem_req_valid, bus.imem_req_addr);
        end
    endtask

    task automatic test_resp_err();
        drive_fetch(32'h0bad_f00d, 1'b1);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_err !== 1'b1 || bus.out_inst !== 32'h0bad_f00d || bus.out_pc !== 64'h8000_0300) begin
            errors++; $display("FAIL err_out got=%b/%b/%h/%h exp=1/1/0badf00d/80000300", bus.out_valid, bus.out_err, bus.out_inst, bus.out_pc);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.imem_req_addr !== 64'h8000_0304) begin errors++; $display("FAIL err_next_pc got=%h exp=80000304", bus.imem_req_addr); end
    endtask

    task automatic test_reset_mid_wait();
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        rst = 1'b0;
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.imem_req_addr !== RST_PC || dbg_state !== ST_REQ) begin
            errors++; $display("FAIL rmw_reset got=%b/%h/%0d exp=0/%h/%0d", bus.out_valid, bus.imem_req_addr, dbg_state, RST_PC, ST_REQ);
        end
        rst = 1'b1;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'h5555_aaaa;
        tick();
        bus.imem_resp_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || dbg_state !== ST_REQ || bus.imem_req_valid !== 1'b1) begin
            errors++; $display("FAIL rmw_late_resp got=%b/%0d/%b exp=0/%0d/1", bus.out_valid, dbg_state, bus.imem_req_valid, ST_REQ);
        end
        drive_fetch(32'h0000_0297, 1'b0);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== RST_PC || bus.out_inst !== 32'h0000_0297 || dbg_state !== ST_HOLD) begin
            errors++; $display("FAIL rmw_refetch got=%b/%h/%h exp=1/%h/00000297", bus.out_valid, bus.out_pc, bus.out_inst, RST_PC);
        end
    endtask

    initial begin
        errors              = 0;
        checks              = 0;
        rst                 = 1'b0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.imem_resp_err   = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 64'h0;
        bus.out_ready       = 1'b0;
        test_reset();
        test_sequential();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_consume();
        test_misaligned();
        test_resp_err();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ysyx_22040088_fetch.md
Name: ysyx_22040088_fetch

Overview:
- Instruction-fetch stage placed directly upstream of the IDU. It replaces the free-running PC plus external instruction input.
- Owns the architectural fetch PC, starting from RESET_PC.
- Issues one instruction-memory request at a time over a valid/ready request channel and a valid response channel.
- Presents {pc, inst, err} to the decode stage through a valid/ready output register.
- Accepts redirects (branch, jump, trap) from EXU and squashes any in-flight fetch.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000: PC after reset.
- XLEN, 64: PC and address width.
- INST_W, 32: instruction width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-low (0 = reset)
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address (= pc)
- imem_resp_valid  in  1  response valid; one cycle per response
- imem_resp_data  in  INST_W  fetched instruction
- imem_resp_err  in  1  access fault for this response
- redirect_valid  in  1  EXU redirect strobe
- redirect_pc  in  XLEN  redirect target
- out_valid  out  1  fetched instruction valid to IDU
- out_ready  in  1  IDU accepts instruction
- out_inst  out  INST_W  instruction
- out_pc  out  XLEN  PC of out_inst
- out_err  out  1  fetch fault (access error or misaligned PC)

Behaviour:
- Reset (rst=0 at a clock edge):
  - state<=REQ, pc<=RESET_PC, kill<=0.
  - out_valid<=0, out_inst<=0, out_pc<=RESET_PC, out_err<=0.
  - imem_req_valid is forced to 0 while rst=0.
  - Reset mid-transaction abandons all state; a response arriving after reset while in REQ is ignored.
- imem_req_valid = (state==REQ) && rst && (pc[1:0]==0). imem_req_addr = pc at all times.
- The request handshake completes on imem_req_valid && imem_req_ready. At most one request is outstanding.
- State REQ:
  - pc[1:0]!=0 and no redirect: no memory access. Next cycle state=HOLD, out_valid=1, out_inst=0, out_err=1, out_pc=pc.
  - Handshake and no redirect: go to WAIT, kill<=0.
  - Redirect: pc<=redirect_pc. If the handshake completes in the same cycle, go to WAIT with kill<=1; otherwise stay in REQ.
  - imem_req_addr must stay stable while valid && !ready. The only exception is a redirect, which changes the address from the next cycle.
- State WAIT:
  - Redirect with no response: pc<=redirect_pc, kill<=1, stay in WAIT.
  - Response with (kill || redirect_valid): discard the data, kill<=0, go to REQ. If redirect_valid, also pc<=redirect_pc.
  - Response otherwise: out_inst<=resp_data, out_err<=resp_err, out_pc<=pc, out_valid<=1, go to HOLD.
  - Latency: the earliest out_valid is 1 cycle after resp_valid. With ready=1 and a same-cycle response, the minimum is 3 cycles per instruction.
- State HOLD (out_valid=1):
  - out_* must stay stable until out_ready.
  - out_ready and no redirect: pc<=pc+4 (wraps modulo 2^XLEN), out_valid<=0, go to REQ.
  - Redirect, with or without out_ready: out_valid<=0, pc<=redirect_pc, go to REQ. If out_ready=1 in the same cycle, the IDU has consumed the instruction; the redirect only replaces pc+4.
- imem_resp_valid in REQ or HOLD is spurious and ignored.
- A redirect to a misaligned target goes through the REQ misaligned path.
- An instruction with err=1 is delivered like any other. The fetch stage does not stall on a fault; traps are handled downstream.
- Redirect always beats sequential pc+4 when both happen in the same cycle.

Test Plan:
- Reset, then memory with req_ready=1, 1-cycle response, and out_ready=1 -> out_pc sequence 0x80000000, 0x80000004, 0x80000008; out_valid once every 3 cycles; out_inst matches memory.
- Hold out_ready=0 for 5 cycles in HOLD -> out_valid, out_pc and out_inst stay stable; no imem_req_valid asserted; pc+4 only after out_ready=1.
- Redirect to 0x80000100 while in WAIT, response arrives 2 cycles later -> that response is dropped; next request address is 0x80000100; out_pc is never 0x80000004.
- Redirect in the same cycle as out_valid && out_ready -> the instruction counts as consumed; next imem_req_addr = redirect_pc, not pc+4.
- Redirect to 0x80000102 -> no memory request; out_valid=1 with out_err=1, out_inst=0, out_pc=0x80000102.
- imem_resp_err=1 on a fetch -> out_err=1. Pull rst low mid-WAIT -> next cycle out_valid=0, pc=RESET_PC, and the late response is ignored.
